// File: rtl/counter_pkg.sv
// Shared defaults and direction encodings for the up/down counter.
package counter_pkg;

   localparam int unsigned WIDTH_DEF   = 8;
   localparam int unsigned RST_VAL_DEF = 0;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage

// File: rtl/counter_next.sv
// Next-count logic: +1 or -1 modulo 2^WIDTH, selected by dir.
module counter_next
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] count,
   input  logic             dir,
   output logic [WIDTH-1:0] next_count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Wrap-around in both directions falls out of WIDTH-bit arithmetic.
   always_comb begin
      next_count = count;
      if (dir_e'(dir) == DIR_UP) begin
         next_count = count + ONE;
      end else begin
         next_count = count - ONE;
      end
   end

endmodule

// File: rtl/counter.sv
// Free-running WIDTH-bit up/down counter with synchronous active-low reset.
module counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned RST_VAL = RST_VAL_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             dir,
   output logic [WIDTH-1:0] c_out
);

   localparam logic [WIDTH-1:0] RST_COUNT = RST_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] next_count;

   counter_next #(
      .WIDTH(WIDTH)
   ) u_next (
      .count     (count),
      .dir       (dir),
      .next_count(next_count)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count <= RST_COUNT;
      end else begin
         count <= next_count;
      end
   end

   assign c_out = count;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: arithmetic reference model plus directed literal checks.
module tb_counter;

   logic       clk;
   logic       resetn;
   logic       dir;
   logic [7:0] c_out;

   int tests_run = 0;
   int tests_failed = 0;

   int model = 0;
   bit model_valid = 0;

   counter #(
      .WIDTH  (8),
      .RST_VAL(0)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .dir   (dir),
      .c_out (c_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: count modulo 256, reset to 0, step chosen by dir.
   always @(posedge clk) begin
      if (!resetn) begin
         model       <= 0;
         model_valid <= 1'b1;
      end else if (model_valid) begin
         model <= dir ? (model + 1) % 256 : (model + 255) % 256;
      end
   end

   always @(negedge clk) begin
      if (model_valid) check("model", c_out, model[7:0]);
   end

   task automatic run(input logic r, input logic d, input int n);
      resetn = r;
      dir    = d;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      resetn = 1'b0;
      dir    = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run(1'b0, 1'b0, 1);
         check("reset_hold", c_out, 8'h00);
      end

      run(1'b1, 1'b0, 1);
      check("down_first", c_out, 8'hFF);
      run(1'b1, 1'b0, 399);
      check("down_400", c_out, 8'h70);

      run(1'b1, 1'b1, 400);
      check("up_400", c_out, 8'h00);

      run(1'b1, 1'b0, 1);
      check("wrap_down", c_out, 8'hFF);
      run(1'b1, 1'b1, 1);
      check("wrap_up", c_out, 8'h00);

      run(1'b1, 1'b1, 90);
      check("reach_5a", c_out, 8'h5A);
      run(1'b0, 1'b1, 1);
      check("reset_mid", c_out, 8'h00);
      run(1'b1, 1'b1, 1);
      check("reset_release", c_out, 8'h01);

      run(1'b1, 1'b1, 15);
      check("reach_10", c_out, 8'h10);
      run(1'b1, 1'b1, 1);
      check("toggle_0", c_out, 8'h11);
      run(1'b1, 1'b0, 1);
      check("toggle_1", c_out, 8'h10);
      run(1'b1, 1'b1, 1);
      check("toggle_2", c_out, 8'h11);
      run(1'b1, 1'b0, 1);
      check("toggle_3", c_out, 8'h10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
